// File: rtl/fft_pkg.sv
// Shared constants and the capture-stage state type for the 512-point FFT slice.
package fft_pkg;

    localparam int NUM_POINTS = 512;
    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        START    = 2'd2,
        WAIT_FFT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/bit_reverse.sv
// Purely combinational bit-order reversal; dout[i] = din[WIDTH-1-i].
module bit_reverse #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Mirror the bit order so linear indices map to decimation-in-time addresses.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign dout[i] = din[WIDTH-1-i];
    end

endmodule

// File: rtl/sample_loader.sv
// Capture stage in front of the FFT core: fills one frame of samples into the
// shared SRAM, kicks the core with a one-cycle fft_start, then holds off input
// until fft_done.
//
// Build option: SAMPLE_LOADER_BIT_REVERSE_EN -- when defined, sram_addr is the
// bit-reversed sample index (decimation-in-time order); otherwise linear.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | not capturing; waits for capture_ena
// FILL     | sample_ready high; one SRAM write per accepted sample
// START    | frame complete; fft_start is raised on the following cycle
// WAIT_FFT | core running; fft_done honoured from the second cycle onward
module sample_loader
    import fft_pkg::*;
#(
    parameter int NUM_POINTS = fft_pkg::NUM_POINTS,
    parameter int ADDR_W     = $clog2(NUM_POINTS),
    parameter int DATA_W     = fft_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              capture_ena,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sram_write_ena,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              busy,
    output logic [7:0]        frame_count
);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_addr;
    logic              accept;
    logic              last_sample;
    logic              wait_armed;
    logic              done_seen;

    assign accept      = sample_valid && sample_ready;
    assign last_sample = (idx == ADDR_W'(NUM_POINTS - 1));
    // A done level left over from the previous run must not end WAIT_FFT on
    // its first cycle, so fft_done only counts once wait_armed is set.
    assign done_seen   = (state == WAIT_FFT) && wait_armed && fft_done;
    assign busy        = (state != IDLE);

`ifdef SAMPLE_LOADER_BIT_REVERSE_EN
    bit_reverse #(
        .WIDTH(ADDR_W)
    ) u_bit_reverse (
        .din (idx),
        .dout(idx_addr)
    );
`else
    assign idx_addr = idx;
`endif

    // Next-state decode for the capture sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (capture_ena) state_next = FILL;
            FILL:     if (accept && last_sample) state_next = START;
            START:    state_next = WAIT_FFT;
            WAIT_FFT: if (done_seen) state_next = capture_ena ? FILL : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // State, handshake outputs, index counter, SRAM write port and frame counter.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state          <= IDLE;
            sample_ready   <= 1'b0;
            fft_start      <= 1'b0;
            wait_armed     <= 1'b0;
            idx            <= '0;
            sram_write_ena <= 1'b0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            frame_count    <= 8'd0;
        end else begin
            state          <= state_next;
            sample_ready   <= (state_next == FILL);
            fft_start      <= (state == START);
            wait_armed     <= (state == WAIT_FFT);
            sram_write_ena <= accept;
            if (accept) begin
                sram_addr  <= idx_addr;
                sram_wdata <= sample_in;
                idx        <= last_sample ? '0 : idx + 1'b1;
            end
            if (done_seen && (frame_count != 8'hFF)) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sample_loader.sv
// Self-checking bench for sample_loader: a scoreboard follows every accepted
// sample to its SRAM write, and scenario tasks check handshake and frame flow.
module tb_sample_loader;

    localparam int NP = 512;
    localparam int AW = 9;
    localparam int DW = 16;
`ifdef SAMPLE_LOADER_BIT_REVERSE_EN
    localparam logic [AW-1:0] IDX1_ADDR = 9'd256;
`else
    localparam logic [AW-1:0] IDX1_ADDR = 9'd1;
`endif

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          capture_ena = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          sram_write_ena;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          fft_start;
    logic          fft_done = 1'b0;
    logic          busy;
    logic [7:0]    frame_count;

    // small-frame instance used for the frame_count saturation run
    logic          s_n_rst = 1'b0;
    logic          s_cena = 1'b1;
    logic [DW-1:0] s_in = 16'h1234;
    logic          s_valid = 1'b1;
    logic          s_ready;
    logic          s_we;
    logic [1:0]    s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_start;
    logic          s_done = 1'b1;
    logic          s_busy;
    logic [7:0]    s_fc;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sample_loader dut (
        .clk(clk), .n_rst(n_rst), .capture_ena(capture_ena),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sram_write_ena(sram_write_ena), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .fft_start(fft_start), .fft_done(fft_done), .busy(busy), .frame_count(frame_count)
    );

    sample_loader #(.NUM_POINTS(4), .ADDR_W(2), .DATA_W(DW)) dut_sat (
        .clk(clk), .n_rst(s_n_rst), .capture_ena(s_cena),
        .sample_in(s_in), .sample_valid(s_valid), .sample_ready(s_ready),
        .sram_write_ena(s_we), .sram_addr(s_addr), .sram_wdata(s_wdata),
        .fft_start(s_start), .fft_done(s_done), .busy(s_busy), .frame_count(s_fc)
    );

    function automatic logic [AW-1:0] exp_addr(input int i);
        logic [AW-1:0] v;
        logic [AW-1:0] r;
        v = i[AW-1:0];
`ifdef SAMPLE_LOADER_BIT_REVERSE_EN
        for (int k = 0; k < AW; k++) r[k] = v[AW-1-k];
`else
        r = v;
`endif
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    bit            mon_on = 1'b0;
    bit            pend = 1'b0;
    logic [DW-1:0] pend_data = '0;
    int            pend_idx = 0;
    int            idx_m = 0;
    int            wr_count = 0;
    int            start_cnt = 0;
    int            sd = 0;
    logic [AW-1:0] addr_idx1 = '1;
    logic [AW-1:0] addr_idx0 = '1;

    always @(negedge clk) begin
        if (mon_on) begin
            logic exp_st;
            checks++;
            if (sram_write_ena !== pend) $display("FAIL write_strobe t=%0t got=%b exp=%b", $time, sram_write_ena, pend);
            else passed++;
            if (pend && sram_write_ena === 1'b1) begin
                checks++;
                if (sram_addr !== exp_addr(pend_idx) || sram_wdata !== pend_data)
                    $display("FAIL write_beat idx=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                             pend_idx, sram_addr, sram_wdata, exp_addr(pend_idx), pend_data);
                else passed++;
                wr_count++;
                if (pend_idx == 1) addr_idx1 = sram_addr;
                if (pend_idx == 0) addr_idx0 = sram_addr;
            end
            exp_st = (sd == 1);
            if (sd > 0) sd--;
            checks++;
            if (fft_start !== exp_st) $display("FAIL fft_start_timing t=%0t got=%b exp=%b", $time, fft_start, exp_st);
            else passed++;
            if (fft_start === 1'b1) start_cnt++;
            if (!n_rst) begin
                idx_m = 0;
                sd    = 0;
                pend  = 1'b0;
            end else begin
                pend = sample_valid && (sample_ready === 1'b1);
                if (pend) begin
                    pend_data = sample_in;
                    pend_idx  = idx_m;
                    if (idx_m == NP - 1) begin
                        idx_m = 0;
                        sd    = 2;
                    end else idx_m++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int fc_m = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, data=index; 1: valid toggles; 2: random valid/data
    task automatic fill(input int n, input int mode, input int drop_at, output int got);
        int cyc;
        cyc = 0;
        got = 0;
        while (got < n && cyc < 4 * NP + 50) begin
            case (mode)
                0:       sample_valid = 1'b1;
                1:       sample_valid = cyc[0];
                default: sample_valid = 1'($urandom_range(0, 1));
            endcase
            sample_in = (mode == 0) ? 16'(got) : 16'($urandom);
            if (got == drop_at) capture_ena = 1'b0;
            @(negedge clk);
            if (sample_valid && sample_ready === 1'b1) got++;
            tick();
            cyc++;
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (fft_start === 1'b1) ok = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_rst        = 1'b0;
        sample_valid = 1'b1;
        capture_ena  = 1'b1;
        sample_in    = 16'($urandom);
        tick();
        mon_on = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({sample_ready, sram_write_ena, fft_start, busy} !== 4'b0 || frame_count !== 8'd0 ||
                sram_addr !== '0 || sram_wdata !== '0)
                $display("FAIL reset_outputs rdy=%b we=%b st=%b busy=%b fc=%0d addr=%0d data=%h exp all zero",
                         sample_ready, sram_write_ena, fft_start, busy, frame_count, sram_addr, sram_wdata);
            else passed++;
            tick();
        end
        sample_valid = 1'b0;
        capture_ena  = 1'b0;
        n_rst        = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (sample_ready !== 1'b0 || busy !== 1'b0) $display("FAIL idle_after_reset rdy=%b busy=%b exp 0 0", sample_ready, busy);
        else passed++;
        tick();
    endtask

    task automatic test_full_frame();
        int wr0, st0, got;
        bit ok;
        wr0 = wr_count;
        st0 = start_cnt;
        capture_ena = 1'b1;
        @(negedge clk);
        checks++;
        if (sample_ready !== 1'b0) $display("FAIL ready_before_capture got=%b exp=0", sample_ready);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (sample_ready !== 1'b1 || busy !== 1'b1) $display("FAIL ready_rise got rdy=%b busy=%b exp 1 1", sample_ready, busy);
        else passed++;
        tick();
        fill(NP, 0, -1, got);
        capture_ena = 1'b0;
        wait_start(ok);
        checks++;
        if (!ok) $display("FAIL full_start_seen got=none exp=pulse");
        else passed++;
        checks++;
        if (sample_ready !== 1'b0 || busy !== 1'b1) $display("FAIL full_ready_after got rdy=%b busy=%b exp 0 1", sample_ready, busy);
        else passed++;
        tick();
        tick();
        checks++;
        if (start_cnt - st0 != 1) $display("FAIL full_start_count got=%0d exp=1", start_cnt - st0);
        else passed++;
        checks++;
        if (wr_count - wr0 != NP) $display("FAIL full_strobes got=%0d exp=%0d", wr_count - wr0, NP);
        else passed++;
        checks++;
        if (addr_idx1 !== IDX1_ADDR) $display("FAIL index1_addr got=%0d exp=%0d", addr_idx1, IDX1_ADDR);
        else passed++;
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        fc_m++;
        @(negedge clk);
        checks++;
        if (frame_count !== 8'(fc_m) || busy !== 1'b0 || sample_ready !== 1'b0)
            $display("FAIL full_done got fc=%0d busy=%b rdy=%b exp fc=%0d busy=0 rdy=0", frame_count, busy, sample_ready, fc_m);
        else passed++;
        tick();
    endtask

    task automatic test_throttled();
        int wr0, got;
        bit ok;
        wr0 = wr_count;
        capture_ena = 1'b1;
        tick();
        fill(NP, 1, -1, got);
        capture_ena = 1'b0;
        checks++;
        if (got != NP) $display("FAIL thr_accepts got=%0d exp=%0d", got, NP);
        else passed++;
        wait_start(ok);
        checks++;
        if (!ok) $display("FAIL thr_start_seen got=none exp=pulse");
        else passed++;
        checks++;
        if (wr_count - wr0 != NP) $display("FAIL thr_strobes got=%0d exp=%0d", wr_count - wr0, NP);
        else passed++;
        tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        fc_m++;
        @(negedge clk);
        checks++;
        if (frame_count !== 8'(fc_m) || busy !== 1'b0) $display("FAIL thr_done got fc=%0d busy=%b exp fc=%0d busy=0", frame_count, busy, fc_m);
        else passed++;
        tick();
    endtask

    task automatic test_handshake();
        int got;
        bit ok;
        capture_ena = 1'b1;
        fft_done    = 1'b1;
        tick();
        fill(NP, 2, -1, got);
        checks++;
        if (got != NP) $display("FAIL hs_accepts got=%0d exp=%0d", got, NP);
        else passed++;
        wait_start(ok);
        checks++;
        if (!ok || busy !== 1'b1 || frame_count !== 8'(fc_m))
            $display("FAIL hs_start got ok=%b busy=%b fc=%0d exp ok=1 busy=1 fc=%0d", ok, busy, frame_count, fc_m);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (frame_count !== 8'(fc_m) || sample_ready !== 1'b0)
            $display("FAIL hs_stale_done got fc=%0d rdy=%b exp fc=%0d rdy=0", frame_count, sample_ready, fc_m);
        else passed++;
        tick();
        fft_done = 1'b0;
        fc_m++;
        @(negedge clk);
        checks++;
        if (frame_count !== 8'(fc_m) || sample_ready !== 1'b1)
            $display("FAIL hs_refill got fc=%0d rdy=%b exp fc=%0d rdy=1", frame_count, sample_ready, fc_m);
        else passed++;
        tick();
    endtask

    task automatic test_mid_cena();
        int got;
        bit ok;
        addr_idx0 = '1;
        fill(NP, 2, 100, got);
        checks++;
        if (got != NP || addr_idx0 !== '0) $display("FAIL cena_frame got accepts=%0d addr0=%0d exp %0d 0", got, addr_idx0, NP);
        else passed++;
        wait_start(ok);
        checks++;
        if (!ok) $display("FAIL cena_start_seen got=none exp=pulse");
        else passed++;
        tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        fc_m++;
        @(negedge clk);
        checks++;
        if (frame_count !== 8'(fc_m) || busy !== 1'b0 || sample_ready !== 1'b0)
            $display("FAIL cena_idle got fc=%0d busy=%b rdy=%b exp fc=%0d 0 0", frame_count, busy, sample_ready, fc_m);
        else passed++;
        tick();
    endtask

    task automatic test_mid_reset();
        int got, wr0;
        bit ok;
        capture_ena = 1'b1;
        tick();
        fill(300, 2, -1, got);
        n_rst       = 1'b0;
        capture_ena = 1'b0;
        tick();
        fc_m = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sample_ready !== 1'b0 || frame_count !== 8'd0)
            $display("FAIL midrst_state got busy=%b rdy=%b fc=%0d exp 0 0 0", busy, sample_ready, frame_count);
        else passed++;
        n_rst = 1'b1;
        tick();
        capture_ena = 1'b1;
        addr_idx0   = '1;
        wr0         = wr_count;
        tick();
        fill(NP, 0, -1, got);
        capture_ena = 1'b0;
        wait_start(ok);
        checks++;
        if (!ok || addr_idx0 !== '0 || wr_count - wr0 != NP)
            $display("FAIL midrst_next got ok=%b addr0=%0d strobes=%0d exp 1 0 %0d", ok, addr_idx0, wr_count - wr0, NP);
        else passed++;
        tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        fc_m++;
        @(negedge clk);
        checks++;
        if (frame_count !== 8'(fc_m)) $display("FAIL midrst_fc got=%0d exp=%0d", frame_count, fc_m);
        else passed++;
        tick();
    endtask

    task automatic test_saturation();
        bit ok;
        int exp_fc;
        s_n_rst = 1'b1;
        for (int f = 1; f <= 258; f++) begin
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                s_in = 16'($urandom);
                if (s_start === 1'b1) ok = 1'b1;
            end
            tick();
            tick();
            @(negedge clk);
            exp_fc = (f > 255) ? 255 : f;
            checks++;
            if (!ok || s_fc !== 8'(exp_fc)) $display("FAIL sat_frame f=%0d got ok=%b fc=%0d exp ok=1 fc=%0d", f, ok, s_fc, exp_fc);
            else passed++;
        end
        s_n_rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at t=%0t exp=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_throttled();
        test_handshake();
        test_mid_cena();
        test_mid_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
